// File: rtl/picosoc_gpio.sv
// picosoc_gpio
// ------------
// Memory-mapped GPIO block for the PicoRV32 native memory bus. It provides:
//   - a WIDTH-bit output register and output-enable register
//   - atomic SET/CLR writes to the output register
//   - a synchronised readback of the input pins
//   - optionally, rising-edge capture with a level interrupt
//
// Optional feature macro:
//   PICOSOC_GPIO_EDGE_IRQ_EN  when defined, builds the edge logic: the prev
//                             flop, the arming counter, EDGE_EN, pend and irq.
//                             When undefined, offsets 0x14/0x18 act as
//                             reserved and irq is tied low.
//
// Ports:
//   clk        in   1      system clock
//   reset_n    in   1      synchronous active-low reset
//   mem_valid  in   1      CPU bus request
//   mem_addr   in   32     byte address
//   mem_wdata  in   32     write data
//   mem_wstrb  in   4      byte write strobes, 0 = read
//   mem_ready  out  1      transfer complete, one-cycle pulse
//   mem_rdata  out  32     read data, 0 whenever mem_ready is 0
//   gpio_in    in   WIDTH  asynchronous pin inputs
//   gpio_out   out  WIDTH  output register
//   gpio_oe    out  WIDTH  output enable, 1 = drive
//   irq        out  1      level interrupt, OR of all pending edges
//
// Register map (offset = mem_addr[4:2] * 4):
//   0x00 OUT  rw | 0x04 OE rw | 0x08 IN ro | 0x0C SET wo | 0x10 CLR wo
//   0x14 EDGE_EN rw | 0x18 EDGE_PEND w1c | 0x1C reserved

module picosoc_gpio #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_valid,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] REG_OUT  = 3'd0;
    localparam logic [2:0] REG_OE   = 3'd1;
    localparam logic [2:0] REG_IN   = 3'd2;
    localparam logic [2:0] REG_SET  = 3'd3;
    localparam logic [2:0] REG_CLR  = 3'd4;
`ifdef PICOSOC_GPIO_EDGE_IRQ_EN
    localparam logic [2:0] REG_EDGE_EN   = 3'd5;
    localparam logic [2:0] REG_EDGE_PEND = 3'd6;
`endif

    // Bus handshake: a transfer is accepted at the edge where mem_valid is
    // high, the address hits this block and no ready pulse is in flight.
    // mem_ready is then high for exactly the following cycle together with
    // mem_rdata; it is forced low in the cycle after, so a master that keeps
    // mem_valid high sees one completion every two cycles. Writes and the
    // read sample both happen at the accepting edge.
    logic       sel;
    logic       xfer;
    logic       wr_en;
    logic       ready_q;
    logic [2:0] reg_idx;

    assign sel     = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign xfer    = sel && !ready_q;
    assign wr_en   = xfer && (mem_wstrb != 4'b0000);
    assign reg_idx = mem_addr[4:2];

    // Byte-lane mask; bits at or above WIDTH simply fall off the slice.
    logic [31:0]      byte_mask;
    logic [31:0]      wr_bits;
    logic [WIDTH-1:0] wr_mask;
    logic [WIDTH-1:0] wr_data;

    assign byte_mask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                        {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
    assign wr_bits   = mem_wdata & byte_mask;
    assign wr_mask   = byte_mask[WIDTH-1:0];
    assign wr_data   = wr_bits[WIDTH-1:0];

    // Output and output-enable registers.
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q <= '0;
            oe_q  <= '0;
        end else if (wr_en) begin
            case (reg_idx)
                REG_OUT: out_q <= (out_q & ~wr_mask) | wr_data;
                REG_OE:  oe_q  <= (oe_q & ~wr_mask) | wr_data;
                REG_SET: out_q <= out_q | wr_data;
                REG_CLR: out_q <= out_q & ~wr_data;
                default: ;
            endcase
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;

    // Input synchroniser chain; stage 0 is the metastability-exposed flop.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef PICOSOC_GPIO_EDGE_IRQ_EN
    // Edge capture. The synchroniser and prev flop reset to 0, so a pin that
    // is already high at reset would look like a rising edge while the chain
    // fills. The arming counter holds off detection until the chain and the
    // prev flop carry real pin history.
    localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_en_q;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] pend_nxt;
    logic [WIDTH-1:0] rise;
    logic [2:0]       arm_cnt;
    logic             armed;

    assign armed = (arm_cnt == ARM_CYCLES);
    assign rise  = sync_in & ~prev_q & {WIDTH{armed}};

    // W1C is applied first and new rises are ORed in after it, so a rise
    // arriving in the same cycle as its clear keeps the bit set.
    always_comb begin
        pend_nxt = pend_q;
        if (wr_en && (reg_idx == REG_EDGE_PEND)) begin
            pend_nxt = pend_nxt & ~wr_data;
        end
        pend_nxt = pend_nxt | (rise & edge_en_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q    <= '0;
            edge_en_q <= '0;
            pend_q    <= '0;
            arm_cnt   <= 3'd0;
        end else begin
            prev_q <= sync_in;
            pend_q <= pend_nxt;
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
            if (wr_en && (reg_idx == REG_EDGE_EN)) begin
                edge_en_q <= (edge_en_q & ~wr_mask) | wr_data;
            end
        end
    end

    assign irq = |pend_q;
`else
    assign irq = 1'b0;
`endif

    // Read multiplexer; write-only and reserved offsets read 0.
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            REG_OUT:       rd_mux[WIDTH-1:0] = out_q;
            REG_OE:        rd_mux[WIDTH-1:0] = oe_q;
            REG_IN:        rd_mux[WIDTH-1:0] = sync_in;
`ifdef PICOSOC_GPIO_EDGE_IRQ_EN
            REG_EDGE_EN:   rd_mux[WIDTH-1:0] = edge_en_q;
            REG_EDGE_PEND: rd_mux[WIDTH-1:0] = pend_q;
`endif
            default:       rd_mux = '0;
        endcase
    end

    // Read data is zero outside the ready pulse so the SoC can OR slaves.
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= xfer;
            rdata_q <= xfer ? rd_mux : 32'd0;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

    // Address byte offset and data bits above WIDTH are not used.
    logic unused_bits;
    assign unused_bits = ^{mem_addr[1:0], wr_bits};

endmodule

// File: tb/tb_picosoc_gpio.sv
// tb_picosoc_gpio
// ---------------
// Directed bench for picosoc_gpio. Two instances share the bus inputs:
// u_dut (WIDTH=8) at 0x0200_0000 and u_dut4 (WIDTH=4) at 0x0300_0000.
// Edge/irq steps follow PICOSOC_GPIO_EDGE_IRQ_EN so the bench matches the
// build being compiled.

module tb_picosoc_gpio;

    localparam logic [31:0] BASE  = 32'h0200_0000;
    localparam logic [31:0] BASE4 = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [7:0]  gpio_in;

    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    logic        mem_ready4;
    logic [31:0] mem_rdata4;
    logic [3:0]  gpio_out4;
    logic [3:0]  gpio_oe4;
    logic        irq4;

    int          n_pass = 0;
    int          n_total = 0;
    logic        irq_at_ready;
    logic [31:0] rd;

    always #5 clk = ~clk;

    picosoc_gpio #(.WIDTH(8), .BASE_ADDR(BASE), .SYNC_STAGES(2)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    picosoc_gpio #(.WIDTH(4), .BASE_ADDR(BASE4), .SYNC_STAGES(2)) u_dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready4),
        .mem_rdata (mem_rdata4),
        .gpio_in   (gpio_in[3:0]),
        .gpio_out  (gpio_out4),
        .gpio_oe   (gpio_oe4),
        .irq       (irq4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic bus_idle();
        mem_valid = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'b0000;
    endtask

    // One transfer: request driven at a negedge, accepted at the next posedge,
    // ready checked high right after that edge and low one cycle later.
    task automatic bus(input bit use4, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        #1;
        check("ready_before_edge", {31'd0, use4 ? mem_ready4 : mem_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", {31'd0, use4 ? mem_ready4 : mem_ready}, 32'd1);
        rdata        = use4 ? mem_rdata4 : mem_rdata;
        irq_at_ready = irq;
        @(negedge clk);
        bus_idle();
        @(posedge clk);
        #1;
        check("ready_one_cycle", {31'd0, use4 ? mem_ready4 : mem_ready}, 32'd0);
        check("rdata_idle_zero", use4 ? mem_rdata4 : mem_rdata, 32'd0);
    endtask

    initial begin
        // Reset held 3 cycles with all pins high.
        reset_n = 1'b0;
        gpio_in = 8'hFF;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        check("rst_gpio_oe", {24'd0, gpio_oe}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        bus(0, BASE + 32'h18, 32'd0, 4'b0000, rd);
        check("pend_after_reset", rd, 32'd0);
        check("irq_after_reset", {31'd0, irq}, 32'd0);

        // Byte lanes and atomic set/clear.
        bus(0, BASE + 32'h00, 32'h0000_00A5, 4'b0001, rd);
        check("out_write_a5", {24'd0, gpio_out}, 32'h0000_00A5);
        bus(0, BASE + 32'h0C, 32'h0000_000A, 4'b1111, rd);
        check("out_set_0a", {24'd0, gpio_out}, 32'h0000_00AF);
        bus(0, BASE + 32'h10, 32'h0000_0081, 4'b1111, rd);
        check("out_clr_81", {24'd0, gpio_out}, 32'h0000_002E);
        bus(0, BASE + 32'h00, 32'h0000_00FF, 4'b0010, rd);
        check("out_unstrobed_lane", {24'd0, gpio_out}, 32'h0000_002E);
        bus(0, BASE + 32'h00, 32'd0, 4'b0000, rd);
        check("rd_out", rd, 32'h0000_002E);
        bus(0, BASE + 32'h04, 32'hFFFF_FF5A, 4'b1111, rd);
        check("oe_write", {24'd0, gpio_oe}, 32'h0000_005A);
        bus(0, BASE + 32'h04, 32'd0, 4'b0000, rd);
        check("rd_oe_upper_zero", rd, 32'h0000_005A);
        bus(0, BASE + 32'h0C, 32'd0, 4'b0000, rd);
        check("rd_set_zero", rd, 32'd0);

        // Synchroniser latency, read continuously with mem_valid held high.
        @(negedge clk);
        gpio_in = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        gpio_in   = 8'h08;
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h08;
        @(posedge clk);
        #1;
        check("in_edge_t_ready", {31'd0, mem_ready}, 32'd1);
        check("in_edge_t_value", mem_rdata, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("in_forced_low_ready", {31'd0, mem_ready}, 32'd0);
        check("in_forced_low_rdata", mem_rdata, 32'd0);
        @(posedge clk);
        #1;
        check("in_edge_t2_ready", {31'd0, mem_ready}, 32'd1);
        check("in_edge_t2_value", mem_rdata, 32'h0000_0008);
        @(negedge clk);
        bus_idle();
        repeat (2) @(posedge clk);

`ifdef PICOSOC_GPIO_EDGE_IRQ_EN
        // Rising edge on an enabled pin raises irq two edges after capture.
        bus(0, BASE + 32'h14, 32'h0000_0010, 4'b1111, rd);
        @(negedge clk);
        gpio_in = 8'h18;
        @(posedge clk);
        #1;
        check("irq_edge_t", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        check("irq_edge_t1", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        check("irq_edge_t2", {31'd0, irq}, 32'd1);
        @(negedge clk);
        gpio_in = 8'h38;
        repeat (4) @(posedge clk);
        bus(0, BASE + 32'h18, 32'd0, 4'b0000, rd);
        check("pend_only_enabled", rd, 32'h0000_0010);
        bus(0, BASE + 32'h18, 32'h0000_0010, 4'b0010, rd);
        check("w1c_wrong_lane_irq", {31'd0, irq}, 32'd1);
        bus(0, BASE + 32'h18, 32'h0000_0010, 4'b0001, rd);
        check("w1c_irq_next_cycle", {31'd0, irq_at_ready}, 32'd0);

        // Clear issued in the same cycle a new rise is captured.
        @(negedge clk);
        gpio_in = 8'h28;
        repeat (4) @(posedge clk);
        @(negedge clk);
        gpio_in = 8'h38;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("setwin_irq_before", {31'd0, irq}, 32'd0);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h18;
        mem_wdata = 32'h0000_0010;
        mem_wstrb = 4'b0001;
        @(posedge clk);
        #1;
        check("setwin_ready", {31'd0, mem_ready}, 32'd1);
        check("setwin_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        bus_idle();
        @(posedge clk);
        #1;
        check("setwin_irq_held", {31'd0, irq}, 32'd1);
        bus(0, BASE + 32'h14, 32'd0, 4'b1111, rd);
        bus(0, BASE + 32'h18, 32'd0, 4'b0000, rd);
        check("pend_kept_after_disable", rd, 32'h0000_0010);
        bus(0, BASE + 32'h18, 32'h0000_00FF, 4'b1111, rd);
        check("pend_cleared_irq", {31'd0, irq}, 32'd0);
`else
        // Without edge support 0x14/0x18 are reserved and irq stays low.
        bus(0, BASE + 32'h14, 32'h0000_00FF, 4'b1111, rd);
        bus(0, BASE + 32'h14, 32'd0, 4'b0000, rd);
        check("edge_en_reserved", rd, 32'd0);
        @(negedge clk);
        gpio_in = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        check("irq_tied_low", {31'd0, irq}, 32'd0);
        bus(0, BASE + 32'h18, 32'd0, 4'b0000, rd);
        check("pend_reserved", rd, 32'd0);
`endif

        // Bus boundary: one block past the window is never acknowledged.
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h20;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("outside_ready", {31'd0, mem_ready}, 32'd0);
            check("outside_rdata", mem_rdata, 32'd0);
        end
        @(negedge clk);
        bus_idle();
        bus(0, BASE + 32'h1C, 32'hFFFF_FFFF, 4'b1111, rd);
        check("reserved_write_no_effect", {24'd0, gpio_out}, 32'h0000_002E);
        bus(0, BASE + 32'h1C, 32'd0, 4'b0000, rd);
        check("reserved_read", rd, 32'd0);

        // Narrow instance drops bits at and above WIDTH.
        bus(1, BASE4 + 32'h00, 32'hFFFF_FFFF, 4'b1111, rd);
        bus(1, BASE4 + 32'h00, 32'd0, 4'b0000, rd);
        check("w4_out_readback", rd, 32'h0000_000F);
        check("w4_gpio_out", {28'd0, gpio_out4}, 32'h0000_000F);

        // Reset asserted in the accepting cycle discards the write and ready.
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h00;
        mem_wdata = 32'h0000_0077;
        mem_wstrb = 4'b0001;
        reset_n   = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_mid_out", {24'd0, gpio_out}, 32'd0);
        @(negedge clk);
        bus_idle();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ready_after", {31'd0, mem_ready}, 32'd0);
        check("rst_mid_out_after", {24'd0, gpio_out}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/picosoc_gpio.md
# picosoc_gpio

Parametrised memory-mapped GPIO peripheral for the PicoRV32 native memory bus. It generalises the fixed 8-bit write-only LED register of the SoC top into a WIDTH-bit block with the following features:
- Output and direction registers.
- Atomic set and clear writes.
- Synchronised input readback.
- Optional rising-edge capture with a level interrupt.

It sits beside RAM and UART on the CPU bus. The top-level OR-combines its `mem_ready` and `mem_rdata` with the other slaves.

## Interface
Parameters:
- `WIDTH`, default 8: number of GPIO pins, 1..32.
- `BASE_ADDR`, default 32'h0200_0000: block base, 32-byte aligned.
- `SYNC_STAGES`, default 2: input synchroniser depth, 2..4.

Ports (reset `reset_n`, synchronous, active-low; clock `clk`):
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous active-low reset
- `mem_valid`  in  1  CPU bus request
- `mem_addr`  in  32  byte address
- `mem_wdata`  in  32  write data
- `mem_wstrb`  in  4  byte write strobes; 0 means read
- `mem_ready`  out  1  transfer complete, one-cycle pulse
- `mem_rdata`  out  32  read data; 0 whenever `mem_ready` is 0
- `gpio_in`  in  WIDTH  asynchronous pin inputs
- `gpio_out`  out  WIDTH  output register
- `gpio_oe`  out  WIDTH  output enable, 1 = drive
- `irq`  out  1  level interrupt

## Operation
- Select: sel = `mem_valid` && `mem_addr`[31:5] == `BASE_ADDR`[31:5].
- Register map, by offset in `mem_addr`[4:2]:
  - 0x00 OUT: read/write.
  - 0x04 OE: read/write.
  - 0x08 IN: read-only, synchronised pins.
  - 0x0C SET: write-only, OUT |= data; reads 0.
  - 0x10 CLR: write-only, OUT &= ~data; reads 0.
  - 0x14 EDGE_EN: read/write.
  - 0x18 EDGE_PEND: write-1-to-clear.
  - 0x1C: reserved; reads 0, writes ignored.
- Byte lanes: every write honours `mem_wstrb` per byte; unstrobed bytes are unchanged, or untouched for SET/CLR/W1C.
- Unused bits: bits at or above `WIDTH` read 0 and ignore writes.
- Input path: `gpio_in` passes through a SYNC_STAGES flop chain, then one "prev" flop. rise = sync & ~prev.
- Edge capture: pend |= rise & EDGE_EN each cycle. A W1C write clears the strobed bits.
- Simultaneous W1C and new rise on the same bit: the bit stays set (set wins).
- `irq` = |pend, combinational from the registers.
- Disabling an EDGE_EN bit does not clear its pend bit.
- Arming: edge detection is suppressed until SYNC_STAGES+1 cycles after reset release, so that pins high at reset produce no spurious pend.
- Reset values: all of the following are 0 — `gpio_out`, `gpio_oe`, EDGE_EN, pend, synchroniser, prev, `mem_ready`, `mem_rdata`, `irq`.
- Reset mid-transfer: a pending `mem_ready` is dropped and register writes in that cycle are discarded.

## Timing
- Latency: one wait state. sel seen at edge k gives `mem_ready`=1 during cycle k+1, with `mem_rdata` valid in the same cycle.
- `mem_ready` is forced low in the cycle after it pulses, even if `mem_valid` is still high. This makes back-to-back transfers 2 cycles each.
- Writes take effect at edge k. `gpio_out`/`gpio_oe` show the new value in cycle k+1.
- Read value: IN returns the synchroniser output sampled at edge k.
- Pin to IN: a pin change before edge t is visible in IN from edge t+SYNC_STAGES-1.
- Pin to `irq`: pend is set at edge t+SYNC_STAGES, and `irq` rises in the same cycle.
- Non-selected addresses: `mem_ready` stays 0 and `mem_rdata` stays 0.

## Configuration
- `PICOSOC_GPIO_EDGE_IRQ_EN` defined: prev flop, arming counter, EDGE_EN, pend and `irq` are built as described above.
- Undefined:
  - 0x14/0x18 behave as reserved: read 0, writes ignored, `mem_ready` still pulses.
  - `irq` is tied to 0.
  - No edge logic is generated.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `gpio_in`=8'hFF → `gpio_out`=0, `gpio_oe`=0, `irq`=0. Reading 0x18 after release returns 0.
- Byte lanes: write OUT=32'h0000_00A5 with wstrb=4'b0001, then SET 8'h0A, then CLR 8'h81 → `gpio_out` = 8'hA5, 8'hAF, 8'h2E in turn. Each `mem_ready` is exactly one cycle and 1 cycle after sel.
- Sync latency: with SYNC_STAGES=2, toggle `gpio_in`[3] 0→1 and poll IN every cycle → bit 3 reads 1 exactly 1 edge after capture, never earlier.
- Edge capture: set EDGE_EN=8'h10 and raise `gpio_in`[4] → `irq`=1 at edge t+2. Raising `gpio_in`[5] does not set pend. Writing 0x18=8'h10 drops `irq` the next cycle.
- Set wins: issue W1C on bit 4 in the same cycle its rise is detected → pend[4] stays 1 and `irq` stays high.
- Bus boundary: an access at `BASE_ADDR`+0x20 gets no `mem_ready`. A read of 0x1C returns 0 with ready. With WIDTH=4, writing OUT=32'hFFFF_FFFF reads back 32'h0000_000F.
